// File: rtl/file_io_arbiter.sv
// Round-robin arbiter that shares one simulation file I/O handler between N_REQ
// per-core detectors, routing completions back and guarding against lost ones.
module file_io_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*32-1:0]      req_instr,
  input  logic [N_REQ*32-1:0]      req_a0,
  input  logic [N_REQ*32-1:0]      req_a1,
  input  logic [N_REQ*32-1:0]      req_a2,
  output logic [N_REQ-1:0]         req_complete,
  output logic                     sim_valid,
  output logic [31:0]              sim_instr,
  output logic [31:0]              sim_a0,
  output logic [31:0]              sim_a1,
  output logic [31:0]              sim_a2,
  output logic [$clog2(N_REQ)-1:0] sim_req_id,
  input  logic                     sim_complete,
  output logic                     busy,
  output logic [N_REQ-1:0]         err_overrun,
  output logic                     err_timeout
);

  localparam int unsigned     ID_W    = $clog2(N_REQ);
  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0]     TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_CPL
  } state_e;

  state_e            stateQ, stateD;
  logic [N_REQ-1:0]  pendQ, pendD;
  logic [31:0]       instrQ [N_REQ];
  logic [31:0]       instrD [N_REQ];
  logic [31:0]       a0Q    [N_REQ];
  logic [31:0]       a0D    [N_REQ];
  logic [31:0]       a1Q    [N_REQ];
  logic [31:0]       a1D    [N_REQ];
  logic [31:0]       a2Q    [N_REQ];
  logic [31:0]       a2D    [N_REQ];
  logic [ID_W-1:0]   grantQ, grantD;
  logic [ID_W-1:0]   lastGrantQ, lastGrantD;
  logic [31:0]       cntQ, cntD;
  logic [31:0]       simInstrQ, simInstrD;
  logic [31:0]       simA0Q, simA0D;
  logic [31:0]       simA1Q, simA1D;
  logic [31:0]       simA2Q, simA2D;
  logic [ID_W-1:0]   simReqIdQ, simReqIdD;
  logic [N_REQ-1:0]  reqCompleteQ, reqCompleteD;
  logic [N_REQ-1:0]  errOverrunQ, errOverrunD;
  logic              errTimeoutQ, errTimeoutD;

  logic              relGrant;
  logic              timeoutHit;
  logic              found;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   cand;

  // First pending slot after the last completed grant, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      cand = ID_W'((int'(lastGrantQ) + k) % int'(N_REQ));
      if (!found && pendQ[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign timeoutHit = TO_EN && (cntQ == TO_LAST);

  always_comb begin
    stateD       = stateQ;
    grantD       = grantQ;
    lastGrantD   = lastGrantQ;
    cntD         = cntQ;
    simInstrD    = simInstrQ;
    simA0D       = simA0Q;
    simA1D       = simA1Q;
    simA2D       = simA2Q;
    simReqIdD    = simReqIdQ;
    reqCompleteD = '0;
    errTimeoutD  = errTimeoutQ;
    relGrant     = 1'b0;
    case (stateQ)
      IDLE: begin
        if (found) begin
          grantD    = pick;
          simInstrD = instrQ[pick];
          simA0D    = a0Q[pick];
          simA1D    = a1Q[pick];
          simA2D    = a2Q[pick];
          simReqIdD = pick;
          stateD    = ISSUE;
        end
      end
      ISSUE: begin
        cntD   = '0;
        stateD = WAIT_CPL;
      end
      WAIT_CPL: begin
        if (sim_complete || timeoutHit) begin
          relGrant             = 1'b1;
          reqCompleteD[grantQ] = 1'b1;
          lastGrantD           = grantQ;
          stateD               = IDLE;
          if (!sim_complete) begin
            errTimeoutD = 1'b1;
          end
        end else begin
          cntD = cntQ + 32'd1;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // A fresh request to the slot being released this cycle is captured, not an overrun.
  always_comb begin
    pendD       = pendQ;
    instrD      = instrQ;
    a0D         = a0Q;
    a1D         = a1Q;
    a2D         = a2Q;
    errOverrunD = errOverrunQ;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req_valid[i] && (!pendQ[i] || (relGrant && grantQ == ID_W'(i)))) begin
        pendD[i]  = 1'b1;
        instrD[i] = req_instr[32*i +: 32];
        a0D[i]    = req_a0[32*i +: 32];
        a1D[i]    = req_a1[32*i +: 32];
        a2D[i]    = req_a2[32*i +: 32];
      end else if (req_valid[i]) begin
        errOverrunD[i] = 1'b1;
      end else if (relGrant && grantQ == ID_W'(i)) begin
        pendD[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      pendQ        <= '0;
      grantQ       <= '0;
      lastGrantQ   <= LAST_ID;
      cntQ         <= '0;
      simInstrQ    <= '0;
      simA0Q       <= '0;
      simA1Q       <= '0;
      simA2Q       <= '0;
      simReqIdQ    <= '0;
      reqCompleteQ <= '0;
      errOverrunQ  <= '0;
      errTimeoutQ  <= 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) begin
        instrQ[i] <= '0;
        a0Q[i]    <= '0;
        a1Q[i]    <= '0;
        a2Q[i]    <= '0;
      end
    end else begin
      pendQ        <= pendD;
      grantQ       <= grantD;
      lastGrantQ   <= lastGrantD;
      cntQ         <= cntD;
      simInstrQ    <= simInstrD;
      simA0Q       <= simA0D;
      simA1Q       <= simA1D;
      simA2Q       <= simA2D;
      simReqIdQ    <= simReqIdD;
      reqCompleteQ <= reqCompleteD;
      errOverrunQ  <= errOverrunD;
      errTimeoutQ  <= errTimeoutD;
      instrQ       <= instrD;
      a0Q          <= a0D;
      a1Q          <= a1D;
      a2Q          <= a2D;
    end
  end

  assign sim_valid    = (stateQ == ISSUE);
  assign busy         = (stateQ != IDLE);
  assign sim_instr    = simInstrQ;
  assign sim_a0       = simA0Q;
  assign sim_a1       = simA1Q;
  assign sim_a2       = simA2Q;
  assign sim_req_id   = simReqIdQ;
  assign req_complete = reqCompleteQ;
  assign err_overrun  = errOverrunQ;
  assign err_timeout  = errTimeoutQ;

endmodule

// File: tb/tb_file_io_arbiter.sv
// Scoreboard bench for file_io_arbiter: expected issues are queued when requests
// are driven and compared when sim_valid appears.
module tb_file_io_arbiter;

  localparam int N_REQ = 4;
  localparam int TO    = 16;
  localparam int ID_W  = 2;
  localparam int EW    = 128 + ID_W;

  logic                clk = 1'b0;
  logic                res_n;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*32-1:0] req_instr;
  logic [N_REQ*32-1:0] req_a0;
  logic [N_REQ*32-1:0] req_a1;
  logic [N_REQ*32-1:0] req_a2;
  logic [N_REQ-1:0]    req_complete;
  logic                sim_valid;
  logic [31:0]         sim_instr;
  logic [31:0]         sim_a0;
  logic [31:0]         sim_a1;
  logic [31:0]         sim_a2;
  logic [ID_W-1:0]     sim_req_id;
  logic                sim_complete;
  logic                busy;
  logic [N_REQ-1:0]    err_overrun;
  logic                err_timeout;
  logic [EW-1:0]       issued;

  int checks = 0;
  int fails  = 0;
  logic [EW-1:0] sbQ[$];

  always #5 clk = ~clk;

  file_io_arbiter #(
    .N_REQ         (N_REQ),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .res_n       (res_n),
    .req_valid   (req_valid),
    .req_instr   (req_instr),
    .req_a0      (req_a0),
    .req_a1      (req_a1),
    .req_a2      (req_a2),
    .req_complete(req_complete),
    .sim_valid   (sim_valid),
    .sim_instr   (sim_instr),
    .sim_a0      (sim_a0),
    .sim_a1      (sim_a1),
    .sim_a2      (sim_a2),
    .sim_req_id  (sim_req_id),
    .sim_complete(sim_complete),
    .busy        (busy),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout)
  );

  assign issued = {sim_instr, sim_a0, sim_a1, sim_a2, sim_req_id};

  task automatic do_reset();
    res_n        = 1'b0;
    req_valid    = '0;
    sim_complete = 1'b0;
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    sbQ.delete();
  endtask

  task automatic load_slot(input int i, input logic [31:0] ins, input logic [31:0] a0,
                           input logic [31:0] a1, input logic [31:0] a2, input bit queueIt);
    req_instr[32*i +: 32] = ins;
    req_a0[32*i +: 32]    = a0;
    req_a1[32*i +: 32]    = a1;
    req_a2[32*i +: 32]    = a2;
    if (queueIt) sbQ.push_back({ins, a0, a1, a2, ID_W'(i)});
  endtask

  task automatic pulse_req(input logic [N_REQ-1:0] mask);
    req_valid = mask;
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic pulse_cpl();
    sim_complete = 1'b1;
    @(negedge clk);
    sim_complete = 1'b0;
  endtask

  task automatic wait_issue(output int cyc);
    cyc = 0;
    while (!sim_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!sim_valid) cyc = -1;
  endtask

  task automatic pop_exp(output logic [EW-1:0] e);
    e = '0;
    if (sbQ.size() > 0) e = sbQ.pop_front();
  endtask

  task automatic test_reset();
    res_n        = 1'b0;
    req_valid    = '0;
    sim_complete = 1'b0;
    req_instr    = '0;
    req_a0       = '0;
    req_a1       = '0;
    req_a2       = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_complete, sim_valid, issued, busy, err_overrun, err_timeout} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs: got %h, want 0",
               {req_complete, sim_valid, issued, busy, err_overrun, err_timeout});
    end
    res_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sim_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL idle_quiet: busy=%b sim_valid=%b, want 0 0", busy, sim_valid);
    end
  endtask

  task automatic test_single();
    int cyc;
    logic [EW-1:0] e;
    do_reset();
    load_slot(2, 32'd3, 32'h8000_1000, 32'h0000_2040, 32'h0, 1'b1);
    pulse_req(4'b0100);
    wait_issue(cyc);
    checks++;
    if (cyc != 1) begin
      fails++;
      $display("[TB] FAIL single_latency: got %0d cycles, want 2", cyc + 1);
    end
    pop_exp(e);
    checks++;
    if (issued !== e) begin
      fails++;
      $display("[TB] FAIL single_issue: got %h, want %h", issued, e);
    end
    @(negedge clk);
    checks++;
    if (sim_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL single_valid_pulse: sim_valid=%b busy=%b, want 0 1", sim_valid, busy);
    end
    repeat (3) @(negedge clk);
    pulse_cpl();
    checks++;
    if (req_complete !== 4'b0100 || issued !== e) begin
      fails++;
      $display("[TB] FAIL single_complete: got cpl=%b issue=%h, want 0100 %h", req_complete, issued, e);
    end
    @(negedge clk);
    checks++;
    if (req_complete !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_cpl_pulse: cpl=%b busy=%b, want 0000 0", req_complete, busy);
    end
  endtask

  task automatic test_contention();
    int cyc;
    int n;
    logic [EW-1:0] e;
    logic [N_REQ-1:0] expMask;
    do_reset();
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 0) begin
        for (int i = 0; i < N_REQ; i++)
          load_slot(i, 32'(i + 1), 32'h1000_0000 + 32'(i * 16), 32'h2000_0000 + 32'(i),
                    32'hA5A5_0000 + 32'(i), 1'b1);
        n = 4;
        pulse_req(4'b1111);
      end else begin
        load_slot(0, 32'd4, 32'h3000_0000, 32'h3100_0000, 32'h3200_0000, 1'b1);
        load_slot(3, 32'd5, 32'h4000_0000, 32'h4100_0000, 32'h4200_0000, 1'b1);
        n = 2;
        pulse_req(4'b1001);
      end
      for (int k = 0; k < n; k++) begin
        wait_issue(cyc);
        pop_exp(e);
        checks++;
        if (cyc < 0 || issued !== e) begin
          fails++;
          $display("[TB] FAIL contention_grant p%0d k%0d: got %h, want %h", phase, k, issued, e);
        end
        @(negedge clk);
        pulse_cpl();
        expMask = '0;
        expMask[e[ID_W-1:0]] = 1'b1;
        checks++;
        if (req_complete !== expMask) begin
          fails++;
          $display("[TB] FAIL contention_complete p%0d k%0d: got %b, want %b", phase, k, req_complete, expMask);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int cyc;
    logic [EW-1:0] e;
    do_reset();
    load_slot(1, 32'd2, 32'h8000_0100, 32'h9000_0000, 32'h1, 1'b1);
    pulse_req(4'b0010);
    load_slot(1, 32'd4, 32'hDEAD_0000, 32'hDEAD_0004, 32'h2, 1'b0);
    pulse_req(4'b0010);
    checks++;
    if (err_overrun !== 4'b0010) begin
      fails++;
      $display("[TB] FAIL overrun_flag: got %b, want 0010", err_overrun);
    end
    wait_issue(cyc);
    pop_exp(e);
    checks++;
    if (cyc < 0 || issued !== e) begin
      fails++;
      $display("[TB] FAIL overrun_first_data: got %h, want %h", issued, e);
    end
    load_slot(1, 32'd5, 32'hBEEF_0000, 32'hBEEF_0004, 32'h3, 1'b0);
    pulse_req(4'b0010);
    pulse_cpl();
    checks++;
    if (req_complete !== 4'b0010) begin
      fails++;
      $display("[TB] FAIL overrun_complete: got %b, want 0010", req_complete);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sim_valid !== 1'b0 || err_overrun !== 4'b0010) begin
      fails++;
      $display("[TB] FAIL overrun_dropped: busy=%b valid=%b ovr=%b, want 0 0 0010", busy, sim_valid, err_overrun);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    logic [EW-1:0] e;
    do_reset();
    load_slot(0, 32'd5, 32'h8000_2000, 32'h8000_3000, 32'h0, 1'b1);
    pulse_req(4'b0001);
    wait_issue(cyc);
    pop_exp(e);
    checks++;
    if (cyc < 0 || issued !== e || err_timeout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL timeout_issue: got %h to=%b, want %h 0", issued, err_timeout, e);
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (req_complete[0] !== 1'b1 && cyc < 40);
    checks++;
    if (cyc != TO + 1) begin
      fails++;
      $display("[TB] FAIL timeout_latency: got %0d cycles after issue, want %0d", cyc, TO + 1);
    end
    checks++;
    if (err_timeout !== 1'b1) begin
      fails++;
      $display("[TB] FAIL timeout_flag: got %b, want 1", err_timeout);
    end
    pulse_cpl();
    checks++;
    if (req_complete !== 4'b0000 || busy !== 1'b0 || err_timeout !== 1'b1) begin
      fails++;
      $display("[TB] FAIL timeout_late_cpl: cpl=%b busy=%b to=%b, want 0000 0 1", req_complete, busy, err_timeout);
    end
  endtask

  task automatic test_same_cycle();
    int cyc;
    logic [EW-1:0] e;
    do_reset();
    load_slot(0, 32'd1, 32'h8000_4000, 32'h8000_4100, 32'h7, 1'b1);
    pulse_req(4'b0001);
    wait_issue(cyc);
    pop_exp(e);
    checks++;
    if (cyc < 0 || issued !== e) begin
      fails++;
      $display("[TB] FAIL same_first: got %h, want %h", issued, e);
    end
    @(negedge clk);
    load_slot(0, 32'd3, 32'h8000_5000, 32'h8000_5100, 32'h8, 1'b1);
    req_valid    = 4'b0001;
    sim_complete = 1'b1;
    @(negedge clk);
    req_valid    = '0;
    sim_complete = 1'b0;
    checks++;
    if (req_complete !== 4'b0001 || err_overrun !== 4'b0000) begin
      fails++;
      $display("[TB] FAIL same_release: cpl=%b ovr=%b, want 0001 0000", req_complete, err_overrun);
    end
    wait_issue(cyc);
    pop_exp(e);
    checks++;
    if (cyc < 0 || issued !== e) begin
      fails++;
      $display("[TB] FAIL same_reissue: got %h, want %h", issued, e);
    end
    @(negedge clk);
    pulse_cpl();
    checks++;
    if (req_complete !== 4'b0001) begin
      fails++;
      $display("[TB] FAIL same_complete: got %b, want 0001", req_complete);
    end
  endtask

  task automatic test_reset_midop();
    int cyc;
    bit sawCpl;
    logic [EW-1:0] e;
    do_reset();
    load_slot(0, 32'd2, 32'h8000_6000, 32'h8000_6100, 32'h0, 1'b1);
    pulse_req(4'b0001);
    wait_issue(cyc);
    pop_exp(e);
    @(negedge clk);
    pulse_cpl();
    load_slot(2, 32'd3, 32'h8000_7000, 32'h8000_7100, 32'h0, 1'b0);
    pulse_req(4'b0100);
    wait_issue(cyc);
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || sim_req_id !== 2'd2) begin
      fails++;
      $display("[TB] FAIL midop_busy: busy=%b id=%0d, want 1 2", busy, sim_req_id);
    end
    res_n = 1'b0;
    @(negedge clk);
    res_n = 1'b1;
    checks++;
    if ({req_complete, sim_valid, issued, busy, err_overrun, err_timeout} !== '0) begin
      fails++;
      $display("[TB] FAIL midop_reset: got %h, want 0",
               {req_complete, sim_valid, issued, busy, err_overrun, err_timeout});
    end
    sawCpl = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (req_complete !== 4'b0000) sawCpl = 1'b1;
    end
    checks++;
    if (sawCpl) begin
      fails++;
      $display("[TB] FAIL midop_no_cpl: got a completion pulse, want none");
    end
    load_slot(0, 32'd1, 32'h8000_8000, 32'h8000_8100, 32'h0, 1'b1);
    load_slot(3, 32'd4, 32'h8000_9000, 32'h8000_9100, 32'h0, 1'b1);
    pulse_req(4'b1001);
    for (int k = 0; k < 2; k++) begin
      wait_issue(cyc);
      pop_exp(e);
      checks++;
      if (cyc < 0 || issued !== e) begin
        fails++;
        $display("[TB] FAIL midop_order k%0d: got %h, want %h", k, issued, e);
      end
      @(negedge clk);
      pulse_cpl();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: still running at %0t, want finished", $time);
    $fatal(1, "[TB] bench hung");
  end

  initial begin
    res_n        = 1'b0;
    req_valid    = '0;
    sim_complete = 1'b0;
    req_instr    = '0;
    req_a0       = '0;
    req_a1       = '0;
    req_a2       = '0;
    test_reset();
    test_single();
    test_contention();
    test_overrun();
    test_timeout();
    test_same_cycle();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
